// File: rtl/raw_mem_wr_ctrl_if.sv
// raw_mem_wr_ctrl_if: trigger, block-FIFO handshake and ring-memory write bus of the raw-hit write controller
interface raw_mem_wr_ctrl_if #(parameter int AW = 8, parameter int DW = 384);
  logic [DW-1:0] din;
  logic          trig;
  logic [AW-1:0] wblock;
  logic          full;
  logic [AW-1:0] adw;
  logic [DW-1:0] dw;
  logic          we;
  logic [AW-1:0] adb;
  logic [AW-1:0] blk_start;
  logic          blk_valid;
  logic          blk_ack;
  logic          rd_done;
  logic          busy;
  logic [7:0]    trig_lost;
  modport slave (
    input  din, trig, wblock, full, blk_ack, rd_done,
    output adw, dw, we, adb, blk_start, blk_valid, busy, trig_lost
  );
  modport master (
    output din, trig, wblock, full, blk_ack, rd_done,
    input  adw, dw, we, adb, blk_start, blk_valid, busy, trig_lost
  );
endinterface

// File: rtl/raw_mem_wr_ctrl.sv
// raw_mem_wr_ctrl: captures wblock-word trigger blocks into the raw-hit ring buffer,
// queues block start addresses for readout and tracks the oldest unretired block.
module raw_mem_wr_ctrl #(
  parameter int AW = 8,
  parameter int DW = 384,
  parameter int QD = 4
) (
  input logic clk,
  input logic rst,
  raw_mem_wr_ctrl_if.slave bus
);
  localparam int QW = $clog2(QD);
  localparam logic [QW:0] QF = (QW+1)'(QD);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t r_state, w_next;
  logic [AW-1:0] r_adw, r_adb, r_cnt, r_start;
  logic [DW-1:0] r_dw;
  logic r_we;
  logic [3:0] r_ocnt;
  logic [7:0] r_lost;
  logic [AW-1:0] r_q [QD];
  logic [QW-1:0] r_wp, r_rp;
  logic [QW:0] r_fcnt;
  logic w_acc, w_last, w_pop, w_ret, w_lost;
  always_comb begin
    w_acc  = r_state == IDLE && bus.trig && !bus.full && r_fcnt != QF && r_ocnt != 4'd15 && bus.wblock != '0;
    w_last = r_state == WRITE && r_cnt == AW'(1);
    w_pop  = bus.blk_ack && r_fcnt != '0;
    w_ret  = bus.rd_done && r_ocnt != '0;
    w_lost = bus.trig && !w_acc && bus.wblock != '0;
    w_next = w_acc ? WRITE : w_last ? IDLE : r_state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_adw <= '0;
      r_adb <= '0;
      r_cnt <= '0;
      r_start <= '0;
      r_dw <= '0;
      r_we <= 1'b0;
      r_ocnt <= '0;
      r_lost <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_fcnt <= '0;
      for (int i = 0; i < QD; i++) r_q[i] <= '0;
    end else begin
      r_dw <= (w_acc || r_state == WRITE) ? bus.din : r_dw;
      if (w_acc) begin
        r_we <= 1'b1;
        r_cnt <= bus.wblock;
        r_start <= r_adw;
      end
      if (r_state == WRITE) begin
        r_adw <= r_adw + AW'(1);
        r_cnt <= r_cnt - AW'(1);
      end
      // the final word's edge closes the block and publishes its start address
      if (w_last) begin
        r_we <= 1'b0;
        r_q[r_wp] <= r_start;
        r_wp <= r_wp + QW'(1);
      end
      if (w_pop) r_rp <= r_rp + QW'(1);
      r_fcnt <= r_fcnt + (QW+1)'(w_last) - (QW+1)'(w_pop);
      r_ocnt <= r_ocnt + 4'(w_last) - 4'(w_ret);
      if (w_ret) r_adb <= r_adb + bus.wblock;
      if (w_lost && r_lost != 8'hff) r_lost <= r_lost + 8'd1;
    end
  assign bus.adw = r_adw;
  assign bus.dw = r_dw;
  assign bus.we = r_we;
  assign bus.adb = r_adb;
  assign bus.blk_start = r_q[r_rp];
  assign bus.blk_valid = r_fcnt != '0;
  assign bus.busy = r_state == WRITE;
  assign bus.trig_lost = r_lost;
endmodule

// File: tb/tb_raw_mem_wr_ctrl.sv
// tb_raw_mem_wr_ctrl: directed and randomized checks of raw_mem_wr_ctrl against a block-level reference model
module tb_raw_mem_wr_ctrl;
  localparam int AW = 8, DW = 384, QD = 4;
  logic clk = 1'b0, rst = 1'b1;
  raw_mem_wr_ctrl_if #(.AW(AW), .DW(DW)) bus();
  raw_mem_wr_ctrl #(.AW(AW), .DW(DW), .QD(QD)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t exp_q[$], obs_q[$];
  int m_fifo[$];
  int m_rem, m_adw, m_adb, m_ocnt, m_lost, m_wa, m_start;
  int n_cmp = 0, n_err = 0;
  task automatic model_clear();
    exp_q.delete(); obs_q.delete(); m_fifo.delete();
    m_rem = 0; m_adw = 0; m_adb = 0; m_ocnt = 0; m_lost = 0; m_wa = 0; m_start = 0;
  endtask
  // one clock: drive inputs, let the model see what the coming edge sees, end at the next falling edge
  task automatic step(input bit t, input bit f, input bit a, input bit r, input logic [DW-1:0] d);
    int w;
    bit acc, ret, pop;
    bus.trig = t; bus.full = f; bus.blk_ack = a; bus.rd_done = r; bus.din = d;
    w = int'(bus.wblock);
    acc = t && m_rem == 0 && !f && m_fifo.size() < QD && m_ocnt < 15 && w != 0;
    ret = r && m_ocnt > 0;
    pop = a && m_fifo.size() > 0;
    if (bus.we) obs_q.push_back({bus.adw, bus.dw});
    if (t && !acc && w != 0 && m_lost < 255) m_lost++;
    if (pop) void'(m_fifo.pop_front());
    if (m_rem > 0) begin
      if (m_rem > 1) begin exp_q.push_back({AW'(m_wa), d}); m_wa = (m_wa + 1) % 256; end
      m_rem--;
      if (m_rem == 0) begin m_fifo.push_back(m_start); m_ocnt++; end
    end
    if (acc) begin
      m_start = m_adw;
      exp_q.push_back({AW'(m_adw), d});
      m_wa = (m_adw + 1) % 256;
      m_adw = (m_adw + w) % 256;
      m_rem = w;
    end
    if (ret) begin m_adb = (m_adb + w) % 256; m_ocnt--; end
    @(posedge clk); @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.trig = 0; bus.full = 0; bus.blk_ack = 0; bus.rd_done = 0; bus.din = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask
  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.adw !== '0 || bus.adb !== '0) begin n_err++; $display("FAIL reset_addr adw=%0d adb=%0d want 0/0", bus.adw, bus.adb); end
    n_cmp++; if (bus.we !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_ctl we=%b busy=%b want 0/0", bus.we, bus.busy); end
    n_cmp++; if (bus.dw !== '0) begin n_err++; $display("FAIL reset_dw nonzero want 0"); end
    n_cmp++; if (bus.blk_valid !== 1'b0 || bus.blk_start !== '0) begin n_err++; $display("FAIL reset_fifo valid=%b start=%0d want 0/0", bus.blk_valid, bus.blk_start); end
    n_cmp++; if (bus.trig_lost !== 8'd0) begin n_err++; $display("FAIL reset_lost got %0d want 0", bus.trig_lost); end
  endtask
  task automatic test_basic();
    bus.wblock = 8'd8;
    for (int c = 0; c < 22; c++) begin
      step(c == 10 || c == 12, 0, 0, 0, DW'(c));
      n_cmp++; if (bus.we !== (c >= 10 && c <= 17)) begin n_err++; $display("FAIL basic_we c=%0d got %b", c, bus.we); end
      n_cmp++; if (bus.blk_valid !== (c >= 18)) begin n_err++; $display("FAIL basic_valid c=%0d got %b", c, bus.blk_valid); end
    end
    n_cmp++; if (obs_q.size() != 8) begin n_err++; $display("FAIL basic_nwr got %0d want 8", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 8; i++) begin
      n_cmp++; if (obs_q[i].a !== AW'(i) || obs_q[i].d !== DW'(10 + i)) begin n_err++; $display("FAIL basic_wr%0d addr=%0d data=%0d want %0d/%0d", i, obs_q[i].a, obs_q[i].d[31:0], i, 10 + i); end
    end
    n_cmp++; if (bus.adw !== 8'd8 || bus.blk_start !== 8'd0) begin n_err++; $display("FAIL basic_end adw=%0d start=%0d want 8/0", bus.adw, bus.blk_start); end
    n_cmp++; if (bus.trig_lost !== 8'd1) begin n_err++; $display("FAIL basic_lost got %0d want 1", bus.trig_lost); end
    step(0, 0, 1, 1, '0);
    n_cmp++; if (bus.adb !== 8'd8 || bus.blk_valid !== 1'b0) begin n_err++; $display("FAIL basic_retire adb=%0d valid=%b want 8/0", bus.adb, bus.blk_valid); end
    step(0, 0, 0, 1, '0);
    n_cmp++; if (bus.adb !== 8'd8) begin n_err++; $display("FAIL basic_retire_empty adb=%0d want 8", bus.adb); end
  endtask
  task automatic test_wrap();
    bit bad;
    do_reset();
    bus.wblock = 8'd1;
    for (int k = 0; k < 252; k++) begin
      step(1, 0, 0, 0, {12{$urandom}});
      step(0, 0, 0, 0, {12{$urandom}});
      step(0, 0, 1, 1, '0);
    end
    n_cmp++; if (bus.adw !== 8'd252 || bus.adb !== 8'd252) begin n_err++; $display("FAIL wrap_preset adw=%0d adb=%0d want 252/252", bus.adw, bus.adb); end
    bad = obs_q.size() != exp_q.size();
    for (int i = 0; i < obs_q.size() && !bad; i++) bad = obs_q[i] !== exp_q[i];
    n_cmp++; if (bad) begin n_err++; $display("FAIL wrap_preset_writes got %0d writes want %0d or data differs", obs_q.size(), exp_q.size()); end
    obs_q.delete(); exp_q.delete();
    bus.wblock = 8'd8;
    for (int c = 0; c < 10; c++) step(c == 0, 0, 0, 0, {12{$urandom}});
    n_cmp++; if (obs_q.size() != 8) begin n_err++; $display("FAIL wrap_nwr got %0d want 8", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 8 && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i].a !== AW'((252 + i) % 256) || obs_q[i].d !== exp_q[i].d) begin n_err++; $display("FAIL wrap_wr%0d addr=%0d want %0d", i, obs_q[i].a, (252 + i) % 256); end
    end
    n_cmp++; if (bus.blk_start !== 8'd252 || bus.blk_valid !== 1'b1 || bus.adw !== 8'd4) begin n_err++; $display("FAIL wrap_end start=%0d valid=%b adw=%0d want 252/1/4", bus.blk_start, bus.blk_valid, bus.adw); end
  endtask
  task automatic test_full();
    do_reset();
    bus.wblock = 8'd4;
    for (int i = 0; i < 300; i++) begin
      step(1, 1, 0, 0, '0);
      if (i == 99) begin n_cmp++; if (bus.trig_lost !== 8'd100) begin n_err++; $display("FAIL full_lost100 got %0d", bus.trig_lost); end end
      if (i == 254) begin n_cmp++; if (bus.trig_lost !== 8'd255) begin n_err++; $display("FAIL full_lost255 got %0d", bus.trig_lost); end end
    end
    n_cmp++; if (bus.trig_lost !== 8'd255) begin n_err++; $display("FAIL full_sat got %0d want 255", bus.trig_lost); end
    n_cmp++; if (obs_q.size() != 0 || bus.adw !== 8'd0) begin n_err++; $display("FAIL full_nowrite writes=%0d adw=%0d want 0/0", obs_q.size(), bus.adw); end
    bus.wblock = 8'd0;
    do_reset();
    step(1, 0, 0, 0, '0);
    n_cmp++; if (bus.trig_lost !== 8'd0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL wblock0 lost=%0d busy=%b want 0/0", bus.trig_lost, bus.busy); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    bus.wblock = 8'd2;
    for (int b = 0; b < 5; b++) begin step(1, 0, 0, 0, {12{$urandom}}); step(0, 0, 0, 0, '0); step(0, 0, 0, 0, '0); end
    n_cmp++; if (bus.trig_lost !== 8'd1 || obs_q.size() != 8) begin n_err++; $display("FAIL b2b_fifo_full lost=%0d writes=%0d want 1/8", bus.trig_lost, obs_q.size()); end
    n_cmp++; if (bus.blk_start !== 8'd0 || bus.blk_valid !== 1'b1) begin n_err++; $display("FAIL b2b_head start=%0d valid=%b want 0/1", bus.blk_start, bus.blk_valid); end
    step(0, 0, 1, 0, '0);
    n_cmp++; if (bus.blk_start !== 8'd2) begin n_err++; $display("FAIL b2b_ack start=%0d want 2", bus.blk_start); end
    step(1, 0, 0, 0, {12{$urandom}}); step(0, 0, 0, 0, '0); step(0, 0, 0, 0, '0);
    n_cmp++; if (bus.trig_lost !== 8'd1 || obs_q.size() != 10) begin n_err++; $display("FAIL b2b_reaccept lost=%0d writes=%0d want 1/10", bus.trig_lost, obs_q.size()); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (bus.blk_valid !== 1'b1 || bus.blk_start !== AW'(2 + 2 * k)) begin n_err++; $display("FAIL b2b_drain%0d start=%0d want %0d", k, bus.blk_start, 2 + 2 * k); end
      step(0, 0, 1, 0, '0);
    end
    n_cmp++; if (bus.blk_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty valid=%b want 0", bus.blk_valid); end
  endtask
  task automatic test_ocnt_limit();
    do_reset();
    bus.wblock = 8'd1;
    for (int k = 0; k < 15; k++) begin step(1, 0, 0, 0, '0); step(0, 0, 0, 0, '0); step(0, 0, 1, 0, '0); end
    step(1, 0, 0, 0, '0);
    n_cmp++; if (bus.trig_lost !== 8'd1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL ocnt15 lost=%0d busy=%b want 1/0", bus.trig_lost, bus.busy); end
    step(0, 0, 0, 1, '0);
    n_cmp++; if (bus.adb !== 8'd1) begin n_err++; $display("FAIL ocnt_retire adb=%0d want 1", bus.adb); end
    step(1, 0, 0, 0, '0);
    n_cmp++; if (bus.busy !== 1'b1 || bus.trig_lost !== 8'd1) begin n_err++; $display("FAIL ocnt_reaccept busy=%b lost=%0d want 1/1", bus.busy, bus.trig_lost); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    bus.wblock = 8'd8;
    for (int c = 0; c < 10; c++) step(c == 0 || c == 2, 0, 0, 0, {12{$urandom}});
    step(1, 0, 0, 0, {12{$urandom}});
    step(0, 0, 0, 0, {12{$urandom}});
    step(0, 0, 0, 0, {12{$urandom}});
    n_cmp++; if (bus.we !== 1'b1 || bus.adw !== 8'd10 || bus.blk_valid !== 1'b1 || bus.trig_lost !== 8'd1) begin n_err++; $display("FAIL mid_pre we=%b adw=%0d valid=%b lost=%0d want 1/10/1/1", bus.we, bus.adw, bus.blk_valid, bus.trig_lost); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.we !== 1'b0 || bus.adw !== 8'd0 || bus.blk_valid !== 1'b0) begin n_err++; $display("FAIL mid_async we=%b adw=%0d valid=%b want 0/0/0", bus.we, bus.adw, bus.blk_valid); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.trig_lost !== 8'd0 || bus.dw !== '0) begin n_err++; $display("FAIL mid_async_state busy=%b lost=%0d want 0/0", bus.busy, bus.trig_lost); end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int c = 0; c < 10; c++) step(0, 0, 0, 0, '0);
    n_cmp++; if (bus.blk_valid !== 1'b0 || obs_q.size() != 0 || bus.adb !== 8'd0) begin n_err++; $display("FAIL mid_after valid=%b writes=%0d adb=%0d want 0/0/0", bus.blk_valid, obs_q.size(), bus.adb); end
  endtask
  task automatic test_random();
    bit bad;
    do_reset();
    bus.wblock = AW'($urandom_range(1, 6));
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, {12{$urandom}});
      n_cmp++; if (bus.adb !== AW'(m_adb) || bus.trig_lost !== 8'(m_lost)) begin n_err++; $display("FAIL rnd_cnt c=%0d adb=%0d lost=%0d want %0d/%0d", c, bus.adb, bus.trig_lost, m_adb, m_lost); end
      n_cmp++; if (bus.busy !== (m_rem > 0) || bus.we !== (m_rem > 0)) begin n_err++; $display("FAIL rnd_busy c=%0d busy=%b we=%b want %0b", c, bus.busy, bus.we, m_rem > 0); end
      n_cmp++; if (bus.blk_valid !== (m_fifo.size() > 0)) begin n_err++; $display("FAIL rnd_valid c=%0d got %b want %0b", c, bus.blk_valid, m_fifo.size() > 0); end
      if (m_fifo.size() > 0) begin n_cmp++; if (bus.blk_start !== AW'(m_fifo[0])) begin n_err++; $display("FAIL rnd_start c=%0d got %0d want %0d", c, bus.blk_start, m_fifo[0]); end end
      if (m_rem == 0) begin n_cmp++; if (bus.adw !== AW'(m_adw)) begin n_err++; $display("FAIL rnd_adw c=%0d got %0d want %0d", c, bus.adw, m_adw); end end
    end
    bad = obs_q.size() != exp_q.size();
    for (int i = 0; i < obs_q.size() && !bad; i++) bad = obs_q[i] !== exp_q[i];
    n_cmp++; if (bad) begin n_err++; $display("FAIL rnd_writes got %0d writes want %0d or data differs", obs_q.size(), exp_q.size()); end
  endtask
  initial begin
    bus.wblock = '0;
    model_clear();
    test_reset();
    test_basic();
    test_wrap();
    test_full();
    test_back_to_back();
    test_ocnt_limit();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/raw_mem_wr_ctrl.md
Name: raw_mem_wr_ctrl

Overview:
- Write-side controller for the 256 x 384 raw-hit ring buffer memory.
- On each accepted trigger, it captures a block of `wblock` consecutive 384-bit words of already-delayed raw hit data and drives the memory's `adw`/`dw`/`we`.
- Owns the oldest-block pointer `adb`, which it advances as downstream readout retires blocks.
- Queues block start addresses for the readout stage and refuses triggers while the memory reports `full`.

Parameters:
- AW, 8, address width; ring depth is 2^AW.
- DW, 384, data word width.
- QD, 4, depth of the block-start address FIFO; power of 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  DW  delayed raw hit word, valid every clock.
- trig  in  1  trigger pulse; one block requested per high cycle.
- wblock  in  AW  words per block; static during a run.
- full  in  1  memory full flag, driven from (adb, adw, wblock).
- adw  out  AW  memory write address.
- dw  out  DW  memory write data, registered.
- we  out  1  memory write enable, registered.
- adb  out  AW  start address of the oldest unretired block.
- blk_start  out  AW  head of the block-start FIFO.
- blk_valid  out  1  FIFO not empty.
- blk_ack  in  1  pops the FIFO head; ignored when `blk_valid`=0.
- rd_done  in  1  downstream finished reading one block; retires it.
- busy  out  1  high while in WRITE.
- trig_lost  out  8  saturating count of refused triggers.

Behaviour:
- Reset (async): `adw`=0, `adb`=0, `we`=0, `dw`=0, `busy`=0, FIFO empty, `blk_valid`=0, `blk_start`=0, `trig_lost`=0, outstanding count `ocnt`=0, state IDLE.
- States: IDLE, WRITE.
- Trigger acceptance, IDLE only: accept when `trig`=1, `full`=0, FIFO not full, `ocnt`<15 and `wblock`!=0. `ocnt` is 4 bits.
- On acceptance:
  - `we`<=1, `dw`<=din, load word counter with `wblock`, capture start address S=`adw`.
  - Go to WRITE; `busy`<=1.
- WRITE, each cycle:
  - `adw`<=`adw`+1 (mod 2^AW), `dw`<=din, counter decrements.
  - When the counter reaches 1: `we`<=0 next edge, return to IDLE, push S into the FIFO, `ocnt`+1.
  - Net effect: exactly `wblock` writes at addresses S..S+wblock-1. The first word is `din` sampled on the trigger edge. `adw` ends at S+wblock.
  - `blk_valid` rises on the edge after the last write.
- Refused trigger: any `trig`=1 that is not accepted increments `trig_lost`, saturating at 255. This covers `trig` during WRITE, `full`, FIFO full, and `ocnt`=15.
- `wblock`=0 trigger: silently ignored and not counted.
- `full` is sampled only at acceptance. A block in progress always completes; the memory's 10-word margin guarantees room.
- Retirement: `rd_done`=1 with `ocnt`>0 gives `adb`<=`adb`+`wblock` and `ocnt`-1. `rd_done` with `ocnt`=0 is ignored.
- Same-cycle push and `rd_done`: `ocnt` is unchanged, `adb` still advances.
- FIFO: first-word-fall-through.
  - `blk_ack` and push in the same cycle are both honoured; with the FIFO empty, the pushed entry appears next cycle.
  - Pointers wrap mod QD.
- Wrap-around: `adw` and `adb` roll 255->0 with no special case. `adb`==`adw` with `ocnt`=0 is empty.
- Reset mid-WRITE: the block is abandoned, nothing is pushed, all state returns to reset values. Any partial data in memory is don't-care.

Test Plan:
- Reset, then `wblock`=8, `trig` at cycle 10 with `din`=ramp -> `we` high 8 cycles at `adw`=0..7 carrying ramp values 10..17; `blk_start`=0 and `blk_valid`=1 one cycle after the last write; `adw`=8.
- Second `trig` while `busy` -> `trig_lost`=1, no extra writes; `rd_done` -> `adb`=8, `ocnt`=0.
- Preset `adw`=252 via 252 single-word blocks retired by `rd_done`, `wblock`=8 -> writes at 252..255,0..3, `blk_start`=252, `adw`=4.
- Hold `full`=1 and pulse `trig` 300 times -> no writes, `trig_lost` saturates at 255.
- Five back-to-back blocks without `blk_ack` (QD=4) -> fifth trigger refused; `blk_ack` once -> next trigger accepted.
- Assert `rst` on the 3rd write cycle of an 8-word block -> `we`=0, `adw`=0, `blk_valid`=0 immediately, FIFO empty.
